// File: rtl/ascii_num_formatter.sv
// ascii_num_formatter: serialises a counted stream of signed integers as ASCII decimal text (spaces between, LF at end).
module ascii_num_formatter #(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGITS      = 10,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] num_count,
  input  logic                   clear,
  input  logic [DATA_WIDTH-1:0]  num_data,
  input  logic                   num_valid,
  output logic                   num_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, CONVERT, EMIT_SIGN, EMIT_DIGIT, EMIT_SEP, DONE} state_t;
  state_t state, state_n;

  logic [COUNT_WIDTH-1:0] remaining;
  logic                   neg;
  logic [DATA_WIDTH-1:0]  mag;
  logic [DIGITS*4-1:0]    bcd, bcd_adj;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx, msd;
  logic [3:0]             digit;
  logic                   conv_done;

  assign conv_done = cnt == CW'(DATA_WIDTH);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;

  always_comb begin
    state_n = state;
    if (clear) state_n = IDLE;
    else case (state)
      IDLE:       if (start) state_n = num_count == '0 ? EMIT_SEP : LOAD;
      LOAD:       if (num_valid) state_n = CONVERT;
      CONVERT:    if (conv_done) state_n = neg ? EMIT_SIGN : EMIT_DIGIT;
      EMIT_SIGN:  if (out_ready) state_n = EMIT_DIGIT;
      EMIT_DIGIT: if (out_ready && idx == '0) state_n = EMIT_SEP;
      EMIT_SEP:   if (out_ready) state_n = remaining != '0 ? LOAD : DONE;
      DONE:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // Double-dabble adjust step and leading-digit search; a zero value leaves msd at 0 so one '0' is emitted.
  always_comb begin
    bcd_adj = bcd;
    msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[i*4+:4] = bcd[i*4+:4] >= 4'd5 ? bcd[i*4+:4] + 4'd3 : bcd[i*4+:4];
      if (bcd[i*4+:4] != 4'd0) msd = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      remaining <= '0;
      neg       <= 1'b0;
      mag       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      idx       <= '0;
    end else if (clear) begin
      remaining <= '0;
      neg       <= 1'b0;
      mag       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      idx       <= '0;
    end else case (state)
      IDLE: if (start) remaining <= num_count;
      LOAD: if (num_valid) begin
        neg       <= num_data[DATA_WIDTH-1];
        mag       <= num_data[DATA_WIDTH-1] ? -num_data : num_data;
        remaining <= remaining - COUNT_WIDTH'(1);
        bcd       <= '0;
        cnt       <= '0;
      end
      CONVERT: if (!conv_done) begin
        bcd <= {bcd_adj[DIGITS*4-2:0], mag[DATA_WIDTH-1]};
        mag <= {mag[DATA_WIDTH-2:0], 1'b0};
        cnt <= cnt + CW'(1);
      end else idx <= msd;
      EMIT_DIGIT: if (out_ready && idx != '0) idx <= idx - IW'(1);
      default: ;
    endcase

  always_comb begin
    digit     = bcd[idx*4+:4];
    out_valid = state == EMIT_SIGN || state == EMIT_DIGIT || state == EMIT_SEP;
    out_last  = state == EMIT_SEP && remaining == '0;
    out_data  = state == EMIT_SIGN  ? 8'h2D :
                state == EMIT_DIGIT ? {4'h3, digit} :
                state == EMIT_SEP   ? (remaining != '0 ? 8'h20 : 8'h0A) : 8'h00;
    num_ready = state == LOAD;
    busy      = state != IDLE;
    done      = state == DONE;
  end
endmodule

// File: tb/tb_ascii_num_formatter.sv
// tb_ascii_num_formatter: random and directed frames scored against text produced by $sformatf.
module tb_ascii_num_formatter;
  logic        clk = 0, rst_n = 0, start = 0, clear = 0, num_valid = 0, out_ready = 0;
  logic [15:0] num_count = 0;
  logic [31:0] num_data = 0;
  logic        num_ready, out_valid, out_last, busy, done;
  logic [7:0]  out_data;

  ascii_num_formatter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_count(num_count), .clear(clear),
    .num_data(num_data), .num_valid(num_valid), .num_ready(num_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  int cyc = 0, acc_cyc = 0, done_cnt = 0, nr_cnt = 0, rdy_mode = 0;
  bit lat_armed = 0;
  logic [8:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Monitor: pops the scoreboard on every transfer and checks stall stability.
  initial begin
    logic pv = 0, pr = 0, pc = 0;
    logic [7:0] pd = 0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pv && !pr && !pc) begin
          check("stall_valid", 32'(out_valid), 1);
          check("stall_data", 32'(out_data), 32'(pd));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_byte: got 0x%0h expected no byte", out_data);
          end else begin
            e = exp_q.pop_front();
            check("byte", 32'(out_data), 32'(e[7:0]));
            check("last", 32'(out_last), 32'(e[8]));
          end
        end
        if (lat_armed && out_valid) begin
          check("first_valid_latency", 32'(cyc - acc_cyc), 33);
          lat_armed = 0;
        end
        if (done) done_cnt++;
        if (num_ready) nr_cnt++;
      end
      pv = out_valid; pr = out_ready; pc = clear; pd = out_data;
    end
  end

  task automatic push_num(input int v, input bit more);
    string s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({1'b0, s[i]});
    exp_q.push_back(more ? 9'h020 : 9'h10A);
  endtask

  task automatic run_frame(input int vals[$], input bit slow, input bit meas);
    int n = vals.size();
    int d0 = done_cnt;
    bit got;
    if (n == 0) exp_q.push_back(9'h10A);
    for (int k = 0; k < n; k++) push_num(vals[k], k != n - 1);
    num_count = 16'(n);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int k = 0; k < n; k++) begin
      if (slow) repeat ($urandom_range(0, 6)) begin @(posedge clk); #1; end
      num_valid = 1;
      num_data = vals[k];
      got = 0;
      for (int t = 0; t < 300 && !got; t++) begin
        @(negedge clk);
        got = num_ready;
        @(posedge clk); #1;
      end
      if (!got) check("accept_timeout", 0, 1);
      if (k == 0 && meas) begin acc_cyc = cyc; lat_armed = 1; end
      num_valid = 0;
    end
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("frame_idle", 32'(busy), 0);
    check("done_pulses", 32'(done_cnt - d0), 1);
    check("queue_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int q[$];
    int nr0;
    bit got;
    repeat (3) @(negedge clk);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_num_ready", 32'(num_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (2) @(posedge clk); #1;

    q = {0};                                  run_frame(q, 0, 0);
    q = {12, -7, 305};                        run_frame(q, 0, 1);
    q = {32'sh80000000, 2147483647};          run_frame(q, 0, 0);
    rdy_mode = 1;
    q = {12, -7, 305};                        run_frame(q, 1, 0);
    rdy_mode = 0;
    nr0 = nr_cnt;
    q.delete();                               run_frame(q, 0, 0);
    check("zero_count_no_num_ready", 32'(nr_cnt - nr0), 0);

    rdy_mode = 1;
    for (int r = 0; r < 8; r++) begin
      q.delete();
      for (int j = 0; j < int'($urandom_range(1, 4)); j++)
        case ($urandom_range(0, 3))
          0: q.push_back(int'($urandom));
          1: q.push_back(int'($urandom_range(0, 9)));
          2: q.push_back(-int'($urandom_range(0, 999)));
          default: q.push_back($urandom_range(0, 1) ? 32'sh80000000 : 0);
        endcase
      run_frame(q, r[0], 0);
    end

    // Abort while a digit is held by a stalled receiver.
    rdy_mode = 2;
    @(posedge clk); #1;
    num_count = 1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    num_valid = 1;
    num_data = 123;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = num_ready;
      @(posedge clk); #1;
    end
    num_valid = 0;
    got = 0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = out_valid;
    end
    check("clear_pre_digit", 32'(out_data), 32'h31);
    @(posedge clk); #1;
    clear = 1;
    start = 1;
    @(posedge clk); #1;
    clear = 0;
    start = 0;
    @(negedge clk);
    check("clear_out_valid", 32'(out_valid), 0);
    check("clear_busy", 32'(busy), 0);
    check("clear_num_ready", 32'(num_ready), 0);
    exp_q.delete();
    rdy_mode = 0;
    @(posedge clk); #1;
    q = {5};                                  run_frame(q, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ascii_num_formatter.md
Name: ascii_num_formatter

Overview:
Transmit-side counterpart of the ASCII number receive path. It accepts a counted stream of signed binary integers and serialises them as ASCII decimal text: optional '-', digits, space separators, and a closing line feed. The byte stream is framed with valid/ready/last and feeds the UART packet transmitter as its payload source.

Parameters:
DATA_WIDTH, 32, width of each signed input integer
DIGITS, 10, BCD digit capacity; must satisfy DIGITS >= ceil(DATA_WIDTH*log10(2))
COUNT_WIDTH, 16, width of the number-count field

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; begins a frame (IDLE only)
num_count  input  COUNT_WIDTH  numbers in the frame, latched on start
clear  input  1  synchronous abort to IDLE
num_data  input  DATA_WIDTH  signed two's-complement integer
num_valid  input  1  num_data valid
num_ready  output  1  block accepts num_data this cycle
out_data  output  8  ASCII byte
out_valid  output  1  out_data valid
out_last  output  1  marks final byte of frame (the 0x0A)
out_ready  input  1  downstream accepts byte
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse after final byte handshake

Behaviour:
- Reset: out_data=0x00, out_valid=0, out_last=0, num_ready=0, busy=0, done=0, state IDLE, counters 0.
- States: IDLE, LOAD, CONVERT, EMIT_SIGN, EMIT_DIGIT, EMIT_SEP, DONE.
- IDLE: on start, latch num_count into remaining. If num_count=0, go to EMIT_SEP (emits 0x0A, last=1); otherwise go to LOAD. start outside IDLE is ignored.
- LOAD: num_ready=1. On num_valid && num_ready:
  - latch neg = MSB.
  - latch mag = |num_data| as unsigned DATA_WIDTH; the most negative value maps correctly.
  - decrement remaining; go to CONVERT.
- CONVERT: shift-add-3 (double-dabble) over exactly DATA_WIDTH cycles into DIGITS BCD nibbles.
  - Then find the most significant nonzero digit index; value 0 yields a single '0'.
  - Next state: EMIT_SIGN if neg, else EMIT_DIGIT.
  - First out_valid rises on the clock edge DATA_WIDTH+1 cycles after the accepting edge.
- EMIT_SIGN: present 0x2D; on handshake go to EMIT_DIGIT.
- EMIT_DIGIT: present 0x30+digit, most significant first, one digit per handshake. After the least significant digit's handshake, go to EMIT_SEP.
- EMIT_SEP: present 0x20 if remaining != 0, else present 0x0A with out_last=1.
  - On handshake: to LOAD if remaining != 0, else to DONE.
- DONE: done=1 for one cycle, then IDLE. Outputs valid/last are low in DONE.
- Output handshake: byte transfers when out_valid && out_ready.
  - While out_valid=1 && out_ready=0, out_data/out_last hold stable; out_valid never drops without a transfer (except clear/reset).
  - Consecutive bytes may issue back-to-back with no bubble when out_ready stays high.
- out_valid is low in IDLE, LOAD, CONVERT, DONE. num_ready is high only in LOAD.
- clear: highest priority after reset. Next cycle: state IDLE, out_valid=0, out_last=0, num_ready=0, done=0, counters zeroed. A start coincident with clear is ignored.
- Reset mid-frame: immediate return to reset values; no partial byte completes.
- No sign for zero. No leading zeros. Exactly one space between numbers, none before the 0x0A.

Test Plan:
- start, num_count=1, num_data=0, out_ready=1 -> bytes 0x30,0x0A; last only on 0x0A; done pulses once.
- num_count=3, data 12,-7,305 -> "12 -7 305\n" = 31 32 20 2D 37 20 33 30 35 0A; first out_valid exactly 33 cycles after first accept.
- num_count=2, data -2147483648, 2147483647 -> "-2147483648 2147483647\n" (23 bytes).
- Same 3-number frame with out_ready randomly toggled and num_valid delayed -> identical byte sequence; out_data stable across stalls; no duplicates or drops.
- start with num_count=0 -> single byte 0x0A with out_last=1; num_ready never asserts.
- clear asserted during EMIT_DIGIT of a frame -> out_valid=0 and busy=0 next cycle; a following start with one number 5 yields 0x35,0x0A.
